clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, meaning clk cycles per one-second tick (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_mode  input  1  debounced single-cycle pulse; advances mode.
REQ-005 SHALL have port key_inc  input  1  debounced single-cycle pulse; increments field being set.
REQ-006 SHALL have port hour  output  5  hours, binary 0..23, registered.
REQ-007 SHALL have port min  output  6  minutes, binary 0..59, registered.
REQ-008 SHALL have port sec  output  6  seconds, binary 0..59, registered.
REQ-009 SHALL have port mode  output  2  current mode: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
REQ-010 SHALL have port blink  output  1  display blink phase for field being set.
REQ-011 SHALL have port tick  output  1  one-cycle pulse per elapsed second.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the cycle in which it holds TICK_DIV-1; it SHALL run in every mode.
REQ-013 FSM SHALL be RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing one state per key_mode pulse; no other transitions.
REQ-014 In RUN, tick SHALL increment sec; the new values SHALL be visible on the cycle after tick.
REQ-015 In RUN, sec 59 + tick SHALL give sec 0 and min+1; min 59 with that carry SHALL give min 0 and hour+1; hour 23 with that carry SHALL give hour 0, all in the same update (23:59:59 -> 00:00:00).
REQ-016 In RUN, key_inc SHALL be ignored.
REQ-017 In SET_H/SET_M/SET_S, tick SHALL NOT advance time.
REQ-018 In SET_H/SET_M/SET_S, key_inc SHALL increment only the selected field, wrapping 23->0 (hour) or 59->0 (min, sec), with no carry into other fields.
REQ-019 key_mode and key_inc in the same cycle: key_mode SHALL take effect; key_inc SHALL be discarded.
REQ-020 tick and key_mode in the same cycle in RUN: time SHALL advance and mode SHALL become SET_H in the same update.
REQ-021 On transition SET_S -> RUN, prescaler SHALL be cleared to 0 so the first second after setting is a full TICK_DIV cycles.
REQ-022 blink SHALL be 0 in RUN, SHALL be 0 on the cycle after entering SET_H, and SHALL toggle on every tick while in any SET state.
REQ-023 Out-of-range field values SHALL be unreachable; no input sequence may produce hour > 23 or min/sec > 59.

Reset
REQ-024 While rst is high, hour/min/sec SHALL be 0, mode RUN, prescaler 0, tick 0, blink 0, independent of clk.
REQ-025 Reset asserted mid-set or mid-second SHALL abandon the operation; after release, counting SHALL restart at 00:00:00 with a full first second.

Structure
REQ-026 Mode encodings, MAX_HOUR=23 and MAX_MIN_SEC=59 SHALL live in shared package clock_pkg.
REQ-027 The prescaler SHALL be a sub-module tick_gen (params TICK_DIV; ports clk, rst, clr, tick); FSM and time counters stay in clock_ctrl.

Verification (TICK_DIV=4 unless stated)
REQ-028 Reset, run 12 cycles -> tick on cycles 4, 8, 12; sec 1, 2, 3; mode 0; blink 0.
REQ-029 Preload 23:59:58 via SET mode, return to RUN, 2 ticks -> 23:59:59, then 00:00:00 in one update.
REQ-030 key_mode x1, key_inc x25 -> mode 1, hour 1 (wrap 23->0), min/sec unchanged; ticks in SET_H do not change sec; blink toggles per tick.
REQ-031 key_mode and key_inc in same cycle from SET_M -> mode 3, min unchanged; key_inc in RUN -> no change.
REQ-032 key_mode from SET_S 2 cycles after a tick -> mode 0, next tick exactly 4 cycles later.
REQ-033 rst pulse asynchronous to clk during SET_M with min=30 -> outputs 0 immediately, mode 0; after release, first tick after 4 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the real-time clock block: mode encoding, field
// limits and a wrap-around increment helper used by the time counters.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_e;

  localparam logic [4:0] MAX_HOUR    = 5'd23;
  localparam logic [5:0] MAX_MIN_SEC = 6'd59;

  // Increment with wrap to 0; ">=" keeps any stray value self-correcting.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Signal bundle for the clock_ctrl user side.
//   key_mode/key_inc : single-cycle key pulses towards the clock
//   hour/min/sec     : current time of day
//   mode/blink/tick  : setting state, blink phase, one-second pulse
interface clock_ctrl_if;
  logic       key_mode;
  logic       key_inc;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;
  logic       tick;

  modport master (output key_mode, key_inc,
                  input  hour, min, sec, mode, blink, tick);
  modport slave  (input  key_mode, key_inc,
                  output hour, min, sec, mode, blink, tick);
endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and wraps.
//   clk  : system clock        rst : async active-high reset
//   clr  : synchronous restart of the count at 0
//   tick : high for the single cycle the count holds TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/clock_ctrl.sv
// 24-hour clock with RUN/SET_H/SET_M/SET_S modes.
//   clk, rst          : system clock, async active-high reset
//   key_mode, key_inc : debounced one-cycle key pulses
//   hour, min, sec    : registered binary time fields
//   mode              : 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   blink             : blink phase for the field being set
//   tick              : one-cycle pulse per elapsed second
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick
);
  mode_e      mode_q, mode_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       clr;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    clr     = 1'b0;

    if (key_mode) begin
      case (mode_q)
        MODE_RUN:   mode_d = MODE_SET_H;
        MODE_SET_H: mode_d = MODE_SET_M;
        MODE_SET_M: mode_d = MODE_SET_S;
        MODE_SET_S: begin
          mode_d = MODE_RUN;
          clr    = 1'b1;  // first second after setting is a full period
        end
      endcase
    end

    if (mode_q == MODE_RUN) begin
      // Time advance is independent of key_mode so a same-cycle mode change
      // still counts the second.
      if (tick) begin
        sec_d = wrap_inc(sec_q, MAX_MIN_SEC);
        if (sec_q >= MAX_MIN_SEC) begin
          min_d = wrap_inc(min_q, MAX_MIN_SEC);
          if (min_q >= MAX_MIN_SEC)
            hour_d = 5'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}));
        end
      end
    end else if (key_inc && !key_mode) begin
      case (mode_q)
        MODE_SET_H: hour_d = 5'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}));
        MODE_SET_M: min_d  = wrap_inc(min_q, MAX_MIN_SEC);
        MODE_SET_S: sec_d  = wrap_inc(sec_q, MAX_MIN_SEC);
        default:    ;
      endcase
    end

    // Phase starts at 0 on entry to SET_H and is forced low in RUN.
    if (mode_q == MODE_RUN || mode_d == MODE_RUN) blink_d = 1'b0;
    else if (tick)                                 blink_d = ~blink_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_RUN;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
    end
  end

  assign hour  = hour_q;
  assign min   = min_q;
  assign sec   = sec_q;
  assign mode  = mode_q;
  assign blink = blink_q;
endmodule

// File: tb/tb_clock_ctrl.sv
module tb_clock_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  clock_ctrl_if ifc ();

  always #5 clk = ~clk;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (ifc.key_mode),
    .key_inc  (ifc.key_inc),
    .hour     (ifc.hour),
    .min      (ifc.min),
    .sec      (ifc.sec),
    .mode     (ifc.mode),
    .blink    (ifc.blink),
    .tick     (ifc.tick)
  );

  typedef struct {
    int hour;
    int min;
    int sec;
    int mode;
    int blink;
    int tick;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

  // Reference: time of day as seconds since midnight, prescaler as an int.
  int m_secs, m_mode, m_pre, m_blink;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_secs = 0; m_mode = 0; m_pre = 0; m_blink = 0;
  endfunction

  function automatic void model_edge(input bit km, input bit ki);
    int h, m, s, nmode;
    bit t;
    t = (m_pre == TD - 1);
    nmode = km ? (m_mode + 1) % 4 : m_mode;
    h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
    if (m_mode == 0) begin
      if (t) m_secs = (m_secs + 1) % 86400;
    end else if (ki && !km) begin
      if (m_mode == 1) h = (h + 1) % 24;
      if (m_mode == 2) m = (m + 1) % 60;
      if (m_mode == 3) s = (s + 1) % 60;
      m_secs = h * 3600 + m * 60 + s;
    end
    if (m_mode == 0 || nmode == 0) m_blink = 0;
    else if (t) m_blink = m_blink ^ 1;
    m_pre = (km && m_mode == 3) ? 0 : (m_pre + 1) % TD;
    m_mode = nmode;
  endfunction

  // Called at a negedge; drives one cycle of keys and queues the
  // expected post-edge outputs, then returns at the next negedge.
  task automatic step(input bit km, input bit ki);
    exp_t e;
    ifc.key_mode = km;
    ifc.key_inc  = ki;
    model_edge(km, ki);
    e.hour  = m_secs / 3600;
    e.min   = (m_secs / 60) % 60;
    e.sec   = m_secs % 60;
    e.mode  = m_mode;
    e.blink = m_blink;
    e.tick  = (m_pre == TD - 1) ? 1 : 0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hour"},  int'(ifc.hour),  0);
    chk({tag, "_min"},   int'(ifc.min),   0);
    chk({tag, "_sec"},   int'(ifc.sec),   0);
    chk({tag, "_mode"},  int'(ifc.mode),  0);
    chk({tag, "_blink"}, int'(ifc.blink), 0);
    chk({tag, "_tick"},  int'(ifc.tick),  0);
  endtask

  // Monitor: every clock edge outside reset presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("hour",  int'(ifc.hour),  e.hour);
        chk("min",   int'(ifc.min),   e.min);
        chk("sec",   int'(ifc.sec),   e.sec);
        chk("mode",  int'(ifc.mode),  e.mode);
        chk("blink", int'(ifc.blink), e.blink);
        chk("tick",  int'(ifc.tick),  e.tick);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifc.key_mode = 1'b0;
    ifc.key_inc  = 1'b0;
    #23;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    repeat (12) step(0, 0);

    // Preload 23:59:58 then run across midnight.
    step(1, 0);
    repeat (23) step(0, 1);
    step(1, 0);
    repeat (59) step(0, 1);
    step(1, 0);
    repeat (58) step(0, 1);
    step(1, 0);
    repeat (9) step(0, 0);

    // Hour wrap while setting, ticks frozen, blink toggling.
    step(1, 0);
    repeat (25) step(0, 1);
    repeat (10) step(0, 0);
    step(1, 0);
    step(1, 1);
    step(1, 0);
    repeat (3) step(0, 1);

    // Leave SET_S two cycles after a tick.
    repeat (3) step(1, 0);
    for (int i = 0; i < 2 * TD && m_pre != 1; i++) step(0, 0);
    step(0, 0);
    step(1, 0);
    repeat (6) step(0, 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);

    // Async reset in SET_M with min = 30.
    for (int i = 0; i < 4 && m_mode != 2; i++) step(1, 0);
    for (int i = 0; i < 60 && ((m_secs / 60) % 60) != 30; i++) step(0, 1);
    chk("pre_reset_min", int'(ifc.min), 30);
    ifc.key_mode = 1'b0;
    ifc.key_inc  = 1'b0;
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
